// File: rtl/i2c_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_pkg : idle bus level and default glitch-filter depth for I2C front end |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package i2c_pkg;

  localparam logic        I2C_IDLE_LEVEL         = 1'b1;
  localparam int unsigned I2C_FILTER_LEN_DEFAULT = 3;

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_line_filter : 2-FF sync, optional glitch filter (I2C_GLITCH_FILTER_EN) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int unsigned FILTER_LEN = I2C_FILTER_LEN_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic filt_o,
  output logic dly_o
);

  logic sync1_q;
  logic sync2_q;
  logic filt;
  logic dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= I2C_IDLE_LEVEL;
      sync2_q <= I2C_IDLE_LEVEL;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned      CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             filt_q;
  logic             filt_d;

  // The FILTER_LEN-th consecutive mismatch flips the output; the count never
  // reaches past that point because it clears together with the flip.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= I2C_IDLE_LEVEL;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  logic unused_filter_len;
  assign unused_filter_len = ^FILTER_LEN;
  assign filt              = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= I2C_IDLE_LEVEL;
    end else begin
      dly_q <= filt;
    end
  end

  assign filt_o = filt;
  assign dly_o  = dly_q;

endmodule
`default_nettype wire

// File: rtl/i2c_line_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_line_conditioner : SDA/SCL conditioning, edge/START/STOP strobes, busy |
// | Revision: 1.0  (filter stage enabled by I2C_GLITCH_FILTER_EN)            |
// +--------------------------------------------------------------------------+
module i2c_line_conditioner
  import i2c_pkg::*;
#(
  parameter int unsigned FILTER_LEN = I2C_FILTER_LEN_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sda_i,
  input  logic scl_i,
  output logic sda_f,
  output logic scl_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy
);

  logic sda_d;
  logic scl_d;
  logic busy_q;
  logic busy_d;

  i2c_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sda_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (sda_i),
    .filt_o (sda_f),
    .dly_o  (sda_d)
  );

  i2c_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_scl_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (scl_i),
    .filt_o (scl_f),
    .dly_o  (scl_d)
  );

  // SDA edges only count as START/STOP while SCL was high in both cycles.
  assign scl_rise  =  scl_f & ~scl_d;
  assign scl_fall  = ~scl_f &  scl_d;
  assign start_det =  scl_f &  scl_d & ~sda_f &  sda_d;
  assign stop_det  =  scl_f &  scl_d &  sda_f & ~sda_d;

  always_comb begin
    busy_d = busy_q;
    if (start_det) begin
      busy_d = 1'b1;
    end else if (stop_det) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus_busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_line_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_line_conditioner : randomized bench with window-based line model  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_i2c_line_conditioner;

  localparam int FLEN = 3;
`ifdef I2C_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif
  localparam int EXP_LAT   = FILT_EN ? FLEN + 2 : 2;
  localparam int EXP_SHORT = FILT_EN ? 0 : 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sda_in = 1'b1;
  logic scl_in = 1'b1;
  logic sda_f, scl_f, scl_rise, scl_fall, start_det, stop_det, bus_busy;

  i2c_line_conditioner #(
    .FILTER_LEN (FLEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sda_i     (sda_in),
    .scl_i     (scl_in),
    .sda_f     (sda_f),
    .scl_f     (scl_f),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .bus_busy  (bus_busy)
  );

  always #5 clk = ~clk;

  // Reference model: bit k of the history is the pin level sampled k edges ago.
  // A filtered line flips once the FLEN samples seen by the filter all disagree.
  logic [17:0] h_sda = '1;
  logic [17:0] h_scl = '1;
  logic m_sda_f = 1'b1, m_scl_f = 1'b1, m_sda_d = 1'b1, m_scl_d = 1'b1, m_busy = 1'b0;
  logic m_rise, m_fall, m_start, m_stop;
  logic [6:0] m_vec, dut_vec;

  assign m_rise  =  m_scl_f & ~m_scl_d;
  assign m_fall  = ~m_scl_f &  m_scl_d;
  assign m_start =  m_scl_f &  m_scl_d & ~m_sda_f &  m_sda_d;
  assign m_stop  =  m_scl_f &  m_scl_d &  m_sda_f & ~m_sda_d;
  assign m_vec   = {m_sda_f, m_scl_f, m_rise, m_fall, m_start, m_stop, m_busy};
  assign dut_vec = {sda_f, scl_f, scl_rise, scl_fall, start_det, stop_det, bus_busy};

  function automatic logic line_next(input logic [17:0] h, input logic f);
`ifdef I2C_GLITCH_FILTER_EN
    logic flip = 1'b1;
    for (int k = 2; k <= FLEN + 1; k++) if (h[k] == f) flip = 1'b0;
    return flip ? ~f : f;
`else
    return (h[1] == f) ? f : h[1];
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_sda   <= '1;
      h_scl   <= '1;
      m_sda_f <= 1'b1;
      m_scl_f <= 1'b1;
      m_sda_d <= 1'b1;
      m_scl_d <= 1'b1;
      m_busy  <= 1'b0;
    end else begin
      m_busy  <= m_start ? 1'b1 : (m_stop ? 1'b0 : m_busy);
      m_sda_d <= m_sda_f;
      m_scl_d <= m_scl_f;
      h_sda   <= {h_sda[16:0], sda_in};
      h_scl   <= {h_scl[16:0], scl_in};
      m_sda_f <= line_next({h_sda[16:0], sda_in}, m_sda_f);
      m_scl_f <= line_next({h_scl[16:0], scl_in}, m_scl_f);
    end
  end

  int nchk = 0;
  int nerr = 0;
  int cnt_rise, cnt_fall, cnt_start, cnt_stop, cnt_idle, cnt_busy;
  logic mm_seen;
  logic [6:0] mm_act, mm_exp;
  time mm_t;
  logic sda_cur;

  task automatic clear_obs();
    cnt_rise = 0; cnt_fall = 0; cnt_start = 0; cnt_stop = 0;
    cnt_idle = 0; cnt_busy = 0; mm_seen = 1'b0;
  endtask

  // Drive both pins, then sample every negedge for n cycles.
  task automatic hold(input logic s, input logic c, input int n);
    sda_in = s;
    scl_in = c;
    repeat (n) begin
      @(negedge clk);
      if (dut_vec !== m_vec && !mm_seen) begin
        mm_seen = 1'b1; mm_act = dut_vec; mm_exp = m_vec; mm_t = $time;
      end
      if (scl_rise === 1'b1)  cnt_rise++;
      if (scl_fall === 1'b1)  cnt_fall++;
      if (start_det === 1'b1) cnt_start++;
      if (stop_det === 1'b1)  cnt_stop++;
      if (bus_busy !== 1'b1)  cnt_idle++;
      if (bus_busy !== 1'b0)  cnt_busy++;
    end
  endtask

  task automatic test_reset();
    sda_in = 1'b0; scl_in = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nchk++;
    if (dut_vec !== 7'b1100000) begin
      nerr++; $display("FAIL reset_values: got %b expected %b", dut_vec, 7'b1100000);
    end
    sda_in = 1'b1; scl_in = 1'b1;
    rst_n = 1'b1;
    clear_obs();
    hold(1'b1, 1'b1, 20);
    nchk++;
    if ((cnt_rise + cnt_fall + cnt_start + cnt_stop + cnt_busy) !== 0) begin
      nerr++; $display("FAIL reset_quiet: got %0d strobe/busy cycles expected 0",
                       cnt_rise + cnt_fall + cnt_start + cnt_stop + cnt_busy);
    end
    nchk++;
    if ({sda_f, scl_f} !== 2'b11) begin
      nerr++; $display("FAIL reset_lines: got %b expected 11", {sda_f, scl_f});
    end
  endtask

  task automatic test_glitch();
    clear_obs();
    hold(1'b1, 1'b0, 2);
    hold(1'b1, 1'b1, 12);
    nchk++;
    if (cnt_fall !== EXP_SHORT || cnt_rise !== EXP_SHORT) begin
      nerr++; $display("FAIL glitch_short: got fall=%0d rise=%0d expected %0d each",
                       cnt_fall, cnt_rise, EXP_SHORT);
    end
    clear_obs();
    hold(1'b1, 1'b0, 5);
    hold(1'b1, 1'b1, 12);
    nchk++;
    if (cnt_fall !== 1 || cnt_rise !== 1 || cnt_start !== 0 || cnt_stop !== 0) begin
      nerr++; $display("FAIL glitch_long: got fall=%0d rise=%0d start=%0d stop=%0d expected 1 1 0 0",
                       cnt_fall, cnt_rise, cnt_start, cnt_stop);
    end
    nchk++;
    if (mm_seen) begin
      nerr++; $display("FAIL glitch_model: got %b expected %b at %0t", mm_act, mm_exp, mm_t);
    end
  endtask

  task automatic test_start();
    int k = 0;
    sda_in = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (sda_f === 1'b0) begin k = i; break; end
    end
    nchk++;
    if (k !== EXP_LAT) begin
      nerr++; $display("FAIL start_latency: got %0d edges expected %0d", k, EXP_LAT);
    end
    nchk++;
    if ({start_det, bus_busy} !== 2'b10) begin
      nerr++; $display("FAIL start_strobe: got start,busy=%b expected 10", {start_det, bus_busy});
    end
    @(posedge clk); #1;
    nchk++;
    if ({start_det, bus_busy} !== 2'b01) begin
      nerr++; $display("FAIL start_busy: got start,busy=%b expected 01", {start_det, bus_busy});
    end
    @(negedge clk);
    sda_cur = 1'b0;
  endtask

  task automatic test_byte();
    clear_obs();
    for (int b = 0; b < 9; b++) begin
      hold(sda_cur, 1'b0, 4);
      sda_cur = 1'($urandom_range(0, 1));
      hold(sda_cur, 1'b0, 4);
      hold(sda_cur, 1'b1, 8);
    end
    nchk++;
    if (cnt_rise !== 9 || cnt_fall !== 9 || cnt_start !== 0 || cnt_stop !== 0) begin
      nerr++; $display("FAIL byte_counts: got rise=%0d fall=%0d start=%0d stop=%0d expected 9 9 0 0",
                       cnt_rise, cnt_fall, cnt_start, cnt_stop);
    end
    nchk++;
    if (cnt_idle !== 0 || mm_seen) begin
      nerr++; $display("FAIL byte_model: idle=%0d got %b expected %b", cnt_idle, mm_act, mm_exp);
    end
  endtask

  task automatic test_rstart_stop();
    int k = 0;
    clear_obs();
    hold(sda_cur, 1'b0, 4);
    hold(1'b1, 1'b0, 4);
    hold(1'b1, 1'b1, 8);
    hold(1'b0, 1'b1, 8);
    nchk++;
    if (cnt_start !== 1 || cnt_idle !== 0 || bus_busy !== 1'b1) begin
      nerr++; $display("FAIL rstart: got start=%0d idle=%0d busy=%b expected 1 0 1",
                       cnt_start, cnt_idle, bus_busy);
    end
    hold(1'b0, 1'b0, 4);
    hold(1'b0, 1'b1, 8);
    sda_in = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (stop_det === 1'b1) begin k = i; break; end
    end
    nchk++;
    if (k !== EXP_LAT || bus_busy !== 1'b1) begin
      nerr++; $display("FAIL stop_strobe: got edge %0d busy=%b expected edge %0d busy=1",
                       k, bus_busy, EXP_LAT);
    end
    @(posedge clk); #1;
    nchk++;
    if ({stop_det, bus_busy} !== 2'b00) begin
      nerr++; $display("FAIL stop_clear: got stop,busy=%b expected 00", {stop_det, bus_busy});
    end
    @(negedge clk);
    hold(1'b1, 1'b1, 4);
  endtask

  task automatic test_random();
    clear_obs();
    for (int i = 0; i < 400; i++) begin
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 6)));
    end
    hold(1'b1, 1'b1, 10);
    nchk++;
    if (mm_seen) begin
      nerr++; $display("FAIL random_model: got %b expected %b at %0t", mm_act, mm_exp, mm_t);
    end
  endtask

  task automatic test_midreset();
    clear_obs();
    hold(1'b1, 1'b1, 8);
    hold(1'b0, 1'b1, 8);
    nchk++;
    if (bus_busy !== 1'b1) begin
      nerr++; $display("FAIL midreset_pre: got busy=%b expected 1", bus_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if (dut_vec !== 7'b1100000) begin
      nerr++; $display("FAIL midreset_async: got %b expected %b", dut_vec, 7'b1100000);
    end
    sda_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    hold(1'b1, 1'b1, 12);
    nchk++;
    if (cnt_busy !== 0 || mm_seen) begin
      nerr++; $display("FAIL midreset_post: busy cycles got %0d expected 0, model %b vs %b",
                       cnt_busy, mm_act, mm_exp);
    end
  endtask

  task automatic test_sda_glitch();
    hold(1'b1, 1'b0, 6);
    sda_in = 1'b0;
    @(posedge clk); #1;
    sda_in = 1'b1;
    nchk++;
    if (sda_f !== 1'b1) begin
      nerr++; $display("FAIL sda_glitch_edge0: got %b expected 1", sda_f);
    end
    @(posedge clk); #1;
    nchk++;
    if (sda_f !== (FILT_EN ? 1'b1 : 1'b0)) begin
      nerr++; $display("FAIL sda_glitch_edge1: got %b expected %b", sda_f, FILT_EN ? 1'b1 : 1'b0);
    end
    @(posedge clk); #1;
    nchk++;
    if (sda_f !== 1'b1) begin
      nerr++; $display("FAIL sda_glitch_edge2: got %b expected 1", sda_f);
    end
    @(negedge clk);
    hold(1'b1, 1'b1, 6);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_glitch();
    test_start();
    test_byte();
    test_rstart_stop();
    test_random();
    test_midreset();
    test_sda_glitch();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
